// File: rtl/food_eat.sv
// Food acceptance and eat detection for the snake playfield (IDLE / WAIT / CHECK FSM).
// Latency: eat seen on step at T -> grow/new_food_flag at T+1 -> food check at T+2 -> food_valid at T+3.
// Backpressure: none; step is ignored outside IDLE and rejected food is re-requested indefinitely.
// Optional build macro SNEK_SCORE_EN adds a saturating 8-bit eaten-food counter on score.
module food_eat #(
  parameter int GRID_H = 32,
  parameter int GRID_V = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [4:0] head_h,
  input  logic [4:0] head_v,
  input  logic [4:0] food_h,
  input  logic [4:0] food_v,
  output logic       new_food_flag,
  output logic       grow,
  output logic       food_valid,
  output logic [3:0] retry_cnt,
  output logic [7:0] score
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // One bit wider than the coordinates so a grid size of 32 still compares correctly.
  localparam logic [5:0] H_LIM = 6'(GRID_H);
  localparam logic [5:0] V_LIM = 6'(GRID_V);

  state_t state;

  logic in_range;
  logic head_hit;
  logic eat;

  // Full 5-bit equality; an off-grid head simply never matches valid food.
  assign in_range = ({1'b0, food_h} < H_LIM) && ({1'b0, food_v} < V_LIM);
  assign head_hit = (head_h == food_h) && (head_v == food_v);
  assign eat      = (state == IDLE) && step && head_hit;

  // Control FSM; every output is a register so the generator and renderer see clean edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Food is reloaded by the generator during reset, so go straight to the settle cycle.
      state         <= WAIT;
      new_food_flag <= 1'b0;
      grow          <= 1'b0;
      food_valid    <= 1'b0;
      retry_cnt     <= 4'd0;
    end else begin
      new_food_flag <= 1'b0;
      grow          <= 1'b0;
      case (state)
        IDLE: begin
          if (eat) begin
            grow          <= 1'b1;
            new_food_flag <= 1'b1;
            food_valid    <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // The new position lands on this edge; judge it next cycle.
          state <= CHECK;
        end
        CHECK: begin
          if (in_range && !head_hit) begin
            food_valid <= 1'b1;
            retry_cnt  <= 4'd0;
            state      <= IDLE;
          end else begin
            // Keep asking forever; only the counter saturates.
            new_food_flag <= 1'b1;
            food_valid    <= 1'b0;
            if (retry_cnt != 4'd15) begin
              retry_cnt <= retry_cnt + 4'd1;
            end
            state <= WAIT;
          end
        end
        default: begin
          state <= WAIT;
        end
      endcase
    end
  end

`ifdef SNEK_SCORE_EN
  logic [7:0] score_q;

  // Count eats in step with the grow pulse, holding at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= 8'd0;
    end else if (eat && (score_q != 8'hFF)) begin
      score_q <= score_q + 8'd1;
    end
  end

  assign score = score_q;
`else
  assign score = 8'd0;
`endif

endmodule

// File: tb/tb_food_eat.sv
// Randomized scoreboard bench for food_eat with an event-level reference model.
// Latency: each modelled event is tagged with the clock edge at which the DUT must show it.
// Backpressure: none; a food generator model reloads food on reset or a sampled request.
module tb_food_eat;

  localparam int GH = 32;
  localparam int GV = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic [4:0] head_h = 5'd0;
  logic [4:0] head_v = 5'd0;
  logic [4:0] food_h = 5'd0;
  logic [4:0] food_v = 5'd0;
  logic       new_food_flag;
  logic       grow;
  logic       food_valid;
  logic [3:0] retry_cnt;
  logic [7:0] score;

  food_eat #(.GRID_H(GH), .GRID_V(GV)) dut (
    .clk(clk),
    .rst(rst),
    .step(step),
    .head_h(head_h),
    .head_v(head_v),
    .food_h(food_h),
    .food_v(food_v),
    .new_food_flag(new_food_flag),
    .grow(grow),
    .food_valid(food_valid),
    .retry_cnt(retry_cnt),
    .score(score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    bit g;
    bit n;
    bit v;
    int r;
    int s;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  edge_n = 0;
  bit  mon_en = 1'b0;
  bit  fv_prev = 1'b0;

  // Reference model state: what is visible to the outside, plus when the next food judgement falls.
  bit  m_fv = 1'b0;
  int  m_retry = 0;
  int  m_score = 0;
  int  m_next = -2;   // edge of next food judgement; -1 means waiting for an eat

  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, edge_n);
    end
  endtask

  // Monitor: every cycle with a pulse or a food_valid change consumes one expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
        ev_t m;
        m = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missed_event: nothing seen, expected g=%0d n=%0d v=%0d r=%0d s=%0d at edge %0d",
                 m.g, m.n, m.v, m.r, m.s, m.edge_no);
      end
      if ((grow === 1'b1) || (new_food_flag === 1'b1) || (food_valid !== fv_prev)) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: got g=%0b n=%0b v=%0b r=%0d s=%0d at edge %0d, expected none",
                   grow, new_food_flag, food_valid, retry_cnt, score, edge_n);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.edge_no != edge_n || grow !== e.g || new_food_flag !== e.n || food_valid !== e.v ||
              int'(retry_cnt) != e.r || int'(score) != e.s) begin
            miscompares++;
            $display("FAIL event: got g=%0b n=%0b v=%0b r=%0d s=%0d at edge %0d, expected g=%0d n=%0d v=%0d r=%0d s=%0d at edge %0d",
                     grow, new_food_flag, food_valid, retry_cnt, score, edge_n,
                     e.g, e.n, e.v, e.r, e.s, e.edge_no);
          end
        end
      end
      fv_prev = (food_valid === 1'b1);
    end
  end

  // Apply inputs for the next edge, predict its outcome, then reload food if that edge requests it.
  task automatic tick(input logic r, input logic s, input logic [4:0] hh, input logic [4:0] hv,
                      input logic [4:0] nh, input logic [4:0] nv);
    int  e1;
    bit  load;
    ev_t ev;
    e1 = edge_n + 1;
    rst = r;
    step = s;
    head_h = hh;
    head_v = hv;
    load = r || (new_food_flag === 1'b1);
    if (r) begin
      if (m_fv) begin
        ev = '{e1, 1'b0, 1'b0, 1'b0, 0, 0};
        exp_q.push_back(ev);
      end
      m_fv = 1'b0;
      m_retry = 0;
      m_score = 0;
      m_next = e1 + 2;
    end else if (m_next == e1) begin
      if (int'(food_h) < GH && int'(food_v) < GV && !(food_h == hh && food_v == hv)) begin
        m_fv = 1'b1;
        m_retry = 0;
        m_next = -1;
        ev = '{e1, 1'b0, 1'b0, 1'b1, 0, m_score};
      end else begin
        m_retry = (m_retry < 15) ? m_retry + 1 : 15;
        m_next = e1 + 2;
        ev = '{e1, 1'b0, 1'b1, 1'b0, m_retry, m_score};
      end
      exp_q.push_back(ev);
    end else if (m_next == -1 && s && hh == food_h && hv == food_v) begin
`ifdef SNEK_SCORE_EN
      if (m_score < 255) m_score = m_score + 1;
`endif
      m_fv = 1'b0;
      m_next = e1 + 2;
      ev = '{e1, 1'b1, 1'b1, 1'b0, m_retry, m_score};
      exp_q.push_back(ev);
    end
    @(posedge clk);
    #1;
    if (load) begin
      food_h = nh;
      food_v = nv;
    end
  endtask

  task automatic rand_food(output logic [4:0] h, output logic [4:0] v);
    h = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 4) == 0) v = 5'($urandom_range(24, 31));
    else v = 5'($urandom_range(0, 23));
  endtask

  initial begin
    logic [4:0] nh, nv, hh, hv;
    int eats;
    int budget;
    int exp_score;

    // Reset, then good food at (5,7): accepted two edges after release, no request.
    tick(1, 0, 0, 0, 5, 7);
    chk("rst_new_food_flag", int'(new_food_flag), 0);
    chk("rst_grow", int'(grow), 0);
    chk("rst_food_valid", int'(food_valid), 0);
    chk("rst_retry_cnt", int'(retry_cnt), 0);
    chk("rst_score", int'(score), 0);
    fv_prev = 1'b0;
    mon_en = 1'b1;
    tick(1, 0, 0, 0, 5, 7);
    repeat (4) tick(0, 0, 0, 0, 1, 1);
    chk("first_food_valid", int'(food_valid), 1);

    // Off-grid food (3,27) is re-requested; (3,9) is then accepted.
    tick(1, 0, 0, 0, 3, 27);
    repeat (6) tick(0, 0, 0, 0, 3, 9);
    chk("retry_food_valid", int'(food_valid), 1);
    chk("retry_cleared", int'(retry_cnt), 0);

    // Eat at (10,10), step during WAIT ignored, then reset during an eat's WAIT.
    tick(1, 0, 0, 0, 10, 10);
    repeat (3) tick(0, 0, 0, 0, 12, 12);
    tick(0, 1, 10, 10, 12, 12);
    tick(0, 1, 10, 10, 12, 12);
    repeat (2) tick(0, 0, 0, 0, 14, 14);
    tick(0, 1, 12, 12, 14, 14);
    tick(1, 0, 12, 12, 14, 14);
    chk("abort_grow", int'(grow), 0);
    chk("abort_new_food_flag", int'(new_food_flag), 0);
    chk("abort_food_valid", int'(food_valid), 0);
    chk("abort_retry_cnt", int'(retry_cnt), 0);
    chk("abort_score", int'(score), 0);
    repeat (4) tick(0, 0, 0, 0, 14, 14);

    // Row 30 is off-grid: a long run of rejects saturates the retry counter.
    tick(1, 0, 0, 0, 3, 30);
    repeat (44) tick(0, 0, 0, 0, 3, 30);
    chk("sat_retry_cnt", int'(retry_cnt), 15);
    chk("sat_food_valid", int'(food_valid), 0);
    repeat (4) tick(0, 0, 0, 0, 4, 4);
    chk("sat_recover_valid", int'(food_valid), 1);

    // Random traffic: steps, head often on the food, mixed good/bad food, rare resets.
    repeat (600) begin
      rand_food(nh, nv);
      if ($urandom_range(0, 3) != 0) begin
        hh = food_h;
        hv = food_v;
      end else begin
        hh = 5'($urandom_range(0, 31));
        hv = 5'($urandom_range(0, 31));
      end
      tick(logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 1)), hh, hv, nh, nv);
    end

    // Many eats from a fresh reset to drive the score to saturation.
    tick(1, 0, 0, 0, 1, 1);
    eats = 0;
    for (int i = 0; i < 260; i++) begin
      budget = 0;
      while (m_next != -1 && budget < 60) begin
        tick(0, 0, 0, 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 23)));
        budget++;
      end
      if (m_next != -1) begin
        chk("eat_wait_timeout", budget, 0);
        break;
      end
      tick(0, 1, food_h, food_v, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 23)));
      eats++;
    end
    repeat (4) tick(0, 0, 0, 0, 2, 2);
`ifdef SNEK_SCORE_EN
    exp_score = (eats > 255) ? 255 : eats;
`else
    exp_score = 0;
`endif
    chk("score_after_eats", int'(score), exp_score);

    repeat (6) tick(0, 0, 0, 0, 2, 2);
    chk("pending_events", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
